bidir_responder: RTL



---
 rtl/bidir_bus_pkg.sv | 22 ++
 rtl/bidir_tx_buf.sv | 45 ++++
 rtl/bidir_responder.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/bidir_bus_pkg.sv
// Shared types and constants for the bidirectional byte-bus responder.
package bidir_bus_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StCapture,
        StTurnIn,
        StDrive,
        StTurnOut
    } bidir_state_e;

    localparam int unsigned DEFAULT_WIDTH = 8;
    localparam int unsigned COLL_CNT_MAX  = 255;

    // Counter must reach the larger of the guard and hold lengths.
    function automatic int unsigned cnt_width(input int unsigned turn, input int unsigned hold);
        int unsigned m;
        m = (turn > hold) ? turn : hold;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/bidir_tx_buf.sv
// One-entry response holding register: valid/ready fill, freed by a strobe after transmission.
module bidir_tx_buf
    import bidir_bus_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] tx_data_i,
    input  logic             tx_valid_i,
    output logic             tx_ready_o,
    input  logic             free_i,
    output logic             full_o,
    output logic [WIDTH-1:0] data_o
);

    logic             full_q, full_d;
    logic [WIDTH-1:0] data_q, data_d;

    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (tx_valid_i && !full_q) begin
            full_d = 1'b1;
            data_d = tx_data_i;
        end else if (free_i) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    assign tx_ready_o = !full_q;
    assign full_o     = full_q;
    assign data_o     = data_q;

endmodule

// File: rtl/bidir_responder.sv
// Far-end responder on a shared tristate byte bus: captures requests, answers after a guard gap.
// Optional BIDIR_RESPONDER_COLL_CNT_EN adds a saturating collision counter output.
module bidir_responder
    import bidir_bus_pkg::*;
#(
    parameter int unsigned WIDTH       = DEFAULT_WIDTH,
    parameter int unsigned TURN_CYCLES = 1,
    parameter int unsigned HOLD_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    inout  wire  [WIDTH-1:0] bidir_io,
    input  logic             req_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             rd_valid_o,
    input  logic             rd_ack_i,
    input  logic [WIDTH-1:0] tx_data_i,
    input  logic             tx_valid_i,
    output logic             tx_ready_o,
`ifdef BIDIR_RESPONDER_COLL_CNT_EN
    output logic [7:0]       coll_count_o,
`endif
    output logic             drive_en_o,
    output logic             overrun_o,
    output logic             collision_o
);

    localparam int unsigned     CntW     = cnt_width(TURN_CYCLES, HOLD_CYCLES);
    localparam logic [CntW-1:0] TurnLast = CntW'(TURN_CYCLES - 1);
    localparam logic [CntW-1:0] HoldLast = CntW'(HOLD_CYCLES - 1);

    bidir_state_e     state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             drive_en_q, drive_en_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;
    logic             overrun_q, overrun_d;
    logic             collision_q, collision_d;
    logic             capture, free, buf_full;
    logic [WIDTH-1:0] buf_data;

    bidir_tx_buf #(
        .WIDTH(WIDTH)
    ) u_tx_buf (
        .clk       (clk),
        .rst       (rst),
        .tx_data_i (tx_data_i),
        .tx_valid_i(tx_valid_i),
        .tx_ready_o(tx_ready_o),
        .free_i    (free),
        .full_o    (buf_full),
        .data_o    (buf_data)
    );

    always_comb begin
        state_d     = state_q;
        capture     = 1'b0;
        free        = 1'b0;
        collision_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req_i) begin
                    capture = 1'b1;
                    state_d = StCapture;
                end
            end
            StCapture: begin
                if (!req_i) state_d = StTurnIn;
            end
            StTurnIn: begin
                if (req_i) begin
                    capture = 1'b1;
                    state_d = StCapture;
                end else if (cnt_q == TurnLast) begin
                    state_d = buf_full ? StDrive : StIdle;
                end
            end
            StDrive: begin
                // A colliding initiator wins; the buffered byte is kept for a retry.
                if (req_i) begin
                    collision_d = 1'b1;
                    state_d     = StTurnOut;
                end else if (cnt_q == HoldLast) begin
                    free    = 1'b1;
                    state_d = StTurnOut;
                end
            end
            StTurnOut: begin
                if (cnt_q == TurnLast) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        cnt_d = '0;
        if (state_d == state_q &&
            (state_q == StTurnIn || state_q == StDrive || state_q == StTurnOut)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign drive_en_d = (state_d == StDrive);

    always_comb begin
        rd_data_d  = rd_data_q;
        rd_valid_d = rd_valid_q;
        overrun_d  = overrun_q;
        if (capture) begin
            if (!rd_valid_q || rd_ack_i) begin
                rd_data_d  = bidir_io;
                rd_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (rd_ack_i && rd_valid_q) begin
            rd_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            drive_en_q  <= 1'b0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            overrun_q   <= 1'b0;
            collision_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            drive_en_q  <= drive_en_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            overrun_q   <= overrun_d;
            collision_q <= collision_d;
        end
    end

`ifdef BIDIR_RESPONDER_COLL_CNT_EN
    logic [7:0] coll_cnt_q, coll_cnt_d;

    always_comb begin
        coll_cnt_d = coll_cnt_q;
        if (collision_q && coll_cnt_q != 8'(COLL_CNT_MAX)) coll_cnt_d = coll_cnt_q + 8'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) coll_cnt_q <= '0;
        else     coll_cnt_q <= coll_cnt_d;
    end

    assign coll_count_o = coll_cnt_q;
`endif

    assign bidir_io    = drive_en_q ? buf_data : {WIDTH{1'bz}};
    assign rd_data_o   = rd_data_q;
    assign rd_valid_o  = rd_valid_q;
    assign drive_en_o  = drive_en_q;
    assign overrun_o   = overrun_q;
    assign collision_o = collision_q;

endmodule
